// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control.
// Holds the memory-handshake FSM state type and register-index constants.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the IF/ID sources.
// Ports: idex_memrd/idex_rt (load in ID/EX), ifid_rs/ifid_rt, load_use out.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             idex_memrd,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             load_use
);

    // A load into r0 never creates a dependency.
    assign load_use = idex_memrd && (idex_rt != ZERO_REG) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush sequencer: data-memory wait FSM, load-use bubbles,
// taken-branch flush, wait timeout (sticky err_o) and saturating stall count.
// Ports: clk_i, rst_i (async, active-high); EX/MEM op flags and dmem_ack_i;
// ID/EX load info; IF/ID sources; branch_taken_i. Outputs: dmem_req_o,
// pc/ifid/exmem/memwb stalls, ifid/idex flushes, err_o, stall_cnt_o.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exmem_memrd_i,
    input  logic             exmem_memwr_i,
    input  logic             dmem_ack_i,
    input  logic             idex_memrd_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    output logic             dmem_req_o,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_stall_o,
    output logic             memwb_stall_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_op;
    logic            mem_stall;
    logic            req;
    logic            load_use;
    logic            lu_eff;

    assign mem_op = exmem_memrd_i | exmem_memwr_i;

    hazard_detect u_hazard_detect (
        .idex_memrd (idex_memrd_i),
        .idex_rt    (idex_rt_i),
        .ifid_rs    (ifid_rs_i),
        .ifid_rt    (ifid_rt_i),
        .load_use   (load_use)
    );

    always_comb begin
        req       = 1'b0;
        mem_stall = 1'b0;
        unique case (state)
            S_RUN: begin
                req       = mem_op;
                mem_stall = mem_op & ~dmem_ack_i;
            end
            S_WAIT: begin
                req       = 1'b1;
                mem_stall = ~dmem_ack_i;
            end
            S_ERR: begin
                req       = 1'b0;
                mem_stall = 1'b1;
            end
            default: begin
                req       = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
    end

    // A memory freeze overrides bubbles and flushes.
    assign lu_eff = load_use & ~mem_stall;

    // Everything is gated by reset so the pipe sees no request or
    // stall while rst_i is high, whatever the data inputs show.
    assign dmem_req_o    = req & ~rst_i;
    assign exmem_stall_o = mem_stall & ~rst_i;
    assign memwb_stall_o = mem_stall & ~rst_i;
    assign pc_stall_o    = (mem_stall | lu_eff) & ~rst_i;
    assign ifid_stall_o  = (mem_stall | lu_eff) & ~rst_i;
    assign idex_flush_o  = lu_eff & ~rst_i;
    assign ifid_flush_o  = branch_taken_i & ~mem_stall & ~load_use & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_RUN;
            wait_cnt    <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (mem_stall && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            unique case (state)
                S_RUN: begin
                    if (mem_op && !dmem_ack_i) begin
                        state    <= S_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_LAST) begin
                        state <= S_ERR;
                        err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    err_o <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
